ps2_rx_decoder: RTL and testbench
=================================

Name: ps2_rx_decoder

Overview:
Host-side PS/2 receiver for the keyboard/mouse serial streams produced by the SPI I/O controller block. It has three stages:
- Deserializes 11-bit PS/2 frames sampled in the clk_sys domain.
- Checks parity and framing.
- Assembles keyboard scan-code sequences (E0/F0/E1 prefixes) into the 11-bit toggle-format key event the core already consumes.

It sits between the PS/2 pins (or the internal ps2_kbd_clk/ps2_kbd_data wires) and the core's keyboard matrix logic.

Parameters:
FILTER, 4, consecutive identical samples needed to accept a new ps2_clk level (glitch filter depth)
TIMEOUT, 2000, clk_sys cycles with no accepted ps2_clk falling edge mid-frame before the frame is aborted
TIMEOUT_W, 12, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_clk  in  1  PS/2 clock, idles high, asynchronous to clk_sys
ps2_data  in  1  PS/2 data, asynchronous
rx_byte  out  8  last received data byte
rx_valid  out  1  one-cycle pulse: rx_byte updated with a good frame
parity_err  out  1  one-cycle pulse: frame had bad odd parity
frame_err  out  1  one-cycle pulse: bad start/stop bit or timeout
ps2_key  out  11  {toggle, pressed, extended, code[7:0]}; toggle inverts once per completed key event
key_busy  out  1  high while a prefix sequence is partially received

Behaviour:
- Reset: clk_sys/reset_n only, asynchronous and active-low, applies to all state. rx_byte=0, rx_valid=0, parity_err=0, frame_err=0, ps2_key=0, key_busy=0. Bit FSM=IDLE, decoder=D_IDLE, filtered clk=1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The clk filter accepts a new level after FILTER equal consecutive samples.
  - A falling edge of the filtered clk is a sample strobe; ps2_data is sampled from its synchronizer on that strobe.
- Bit FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: strobe with data=0 -> DATA, bit count=0. Strobe with data=1 is ignored (no error).
  - DATA: 8 strobes, shift LSB first. After the 8th -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on strobe, if stop=1 and the XOR of the 8 data bits and parity =1 (odd parity), rx_byte<=data and rx_valid pulses. If stop=1 but parity fails, parity_err pulses and rx_byte is unchanged. If stop=0, frame_err pulses. All cases return to IDLE.
  - Pulse latency: every pulse is asserted the cycle after the stop-bit strobe.
  - Timeout: in any non-IDLE state, the counter clears on each strobe. When the counter reaches TIMEOUT, frame_err pulses, the FSM goes to IDLE, and the partial byte is discarded.
- Key decoder (consumes rx_valid bytes only; errors never advance it):
  - D_IDLE: E0 -> ext=1, stay. F0 -> brk=1, stay. E1 -> D_SKIP with skip count=7. Any other byte b emits the event and clears ext/brk.
  - Event emission: ps2_key<={~ps2_key[10], ~brk, ext, b}.
  - key_busy = ext | brk | (state==D_SKIP).
  - D_SKIP: swallow 7 bytes. On the 7th, emit {~toggle, 1, 1, 8'h77} (Pause), then go to D_IDLE.
  - Print-Screen make (E0 12 E0 7C): the E0 12 pair is dropped without emitting. The event emitted is {1, 1, 7C} (pressed, extended).
  - Print-Screen break (E0 F0 7C E0 F0 12): only the 7C event is emitted, as a release, {0, 1, 7C}. The trailing E0 F0 12 is dropped.
  - Release format: ps2_key[9:8] is 2'b01 (pressed=0, extended=1) for an extended release and 2'b00 for a normal release.
  - Event latency: ps2_key updates one cycle after the rx_valid that completes the event.
  - Simultaneous events: a frame_err or parity_err during a prefix sequence resets ext, brk and skip, and the decoder returns to D_IDLE. This means a corrupted sequence never emits a wrong key.
- Reset mid-frame: on release, the FSM starts in IDLE. If ps2_clk is low at reset release, no false strobe occurs because the filtered clk resets high and the first strobe needs a real high-to-low transition.
- Wrap: the skip count and bit count never exceed their terminal values. The timeout counter saturates at TIMEOUT.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_CODE=8'h77, PS2_PRTSC=8'h7C, PS2_LSHIFT=8'h12;
  - the bit-FSM and decoder state enums;
  - the ps2_key field offsets (TOGGLE=10, PRESSED=9, EXT=8).
- Sub-module ps2_frame_rx contains the synchronizers, filter, bit FSM and timeout. It is reused by the mouse path.
- The top level adds the key decoder.

Test Plan:
- Send frame 0x1C with good parity (half-period 101 clk_sys) -> rx_valid once, rx_byte=0x1C, ps2_key={1,1,0,1C} from reset.
- Send E0, F0, 75 -> three rx_valid, exactly one key event, ps2_key[9:0]=10'h175 (pressed=0, ext=1 → 0x175), toggle flips once.
- Send 0x1C with parity bit inverted -> parity_err pulse, no rx_valid, ps2_key unchanged.
- Send E1 14 77 E1 F0 14 F0 77 -> one event ps2_key[9:0]=10'h377.
- Send start bit plus 4 data bits, then hold clk high for 2500 cycles -> frame_err at cycle TIMEOUT after the last edge; the next full 0x29 frame is decoded correctly.
- Send 0x1C then a 2-cycle clk glitch with FILTER=4 -> no extra strobe; assert reset_n low mid-frame -> all outputs 0, then 0x5A decodes cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key-field offsets and state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
    localparam logic [7:0] PS2_PRTSC      = 8'h7C;
    localparam logic [7:0] PS2_LSHIFT     = 8'h12;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } bit_state_t;

    typedef enum logic {
        D_IDLE,
        D_SKIP
    } dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, 11-bit frame FSM, timeout.
// Latency: result pulses one clk_sys cycle after the stop-bit strobe.
// Backpressure: none; the PS/2 device owns the clock, so results are single-cycle pulses.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 2000,
    parameter int TIMEOUT_W = 12
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    localparam int FCW = $clog2(FILTER) + 1;

    logic                 r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                 r_filt, r_armed;
    logic [FCW-1:0]       r_fcnt;
    bit_state_t           r_state, w_state_nx;
    logic [7:0]           r_shift, w_shift_nx;
    logic [2:0]           r_bcnt, w_bcnt_nx;
    logic                 r_par, w_par_nx;
    logic [TIMEOUT_W-1:0] r_to, w_to_nx;
    logic [7:0]           r_byte, w_byte_nx;
    logic                 r_valid, r_perr, r_ferr;
    logic                 w_valid_nx, w_perr_nx, w_ferr_nx;
    logic                 w_accept, w_strobe, w_timeout;

    // A strobe needs the filtered clock to have been seen high since reset, so a
    // line held low across reset release never produces a false falling edge.
    assign w_accept  = (r_clk_s2 != r_filt) && (r_fcnt == FCW'(FILTER - 1));
    assign w_strobe  = w_accept && r_filt && r_armed;
    assign w_timeout = (r_state != S_IDLE) && (r_to == TIMEOUT_W'(TIMEOUT));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_armed  <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_armed  <= r_armed | r_clk_s2;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (w_accept) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FCW'(1);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_bcnt_nx  = r_bcnt;
        w_par_nx   = r_par;
        w_to_nx    = r_to;
        w_byte_nx  = r_byte;
        w_valid_nx = 1'b0;
        w_perr_nx  = 1'b0;
        w_ferr_nx  = 1'b0;

        if (r_state == S_IDLE || w_strobe) begin
            w_to_nx = '0;
        end else if (!w_timeout) begin
            w_to_nx = r_to + TIMEOUT_W'(1);
        end

        if (w_timeout) begin
            w_state_nx = S_IDLE;
            w_ferr_nx  = 1'b1;
            w_to_nx    = '0;
        end else if (w_strobe) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nx = S_DATA;
                        w_bcnt_nx  = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nx = {r_dat_s2, r_shift[7:1]};
                    if (r_bcnt == 3'd7) begin
                        w_state_nx = S_PARITY;
                    end else begin
                        w_bcnt_nx = r_bcnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    w_par_nx   = r_dat_s2;
                    w_state_nx = S_STOP;
                end
                S_STOP: begin
                    w_state_nx = S_IDLE;
                    if (!r_dat_s2) begin
                        w_ferr_nx = 1'b1;
                    end else if (^{r_shift, r_par}) begin
                        w_valid_nx = 1'b1;
                        w_byte_nx  = r_shift;
                    end else begin
                        w_perr_nx = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_par   <= 1'b0;
            r_to    <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_bcnt  <= w_bcnt_nx;
            r_par   <= w_par_nx;
            r_to    <= w_to_nx;
            r_byte  <= w_byte_nx;
            r_valid <= w_valid_nx;
            r_perr  <= w_perr_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    assign o_rx_byte    = r_byte;
    assign o_rx_valid   = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: frame reception plus E0/F0/E1 prefix assembly into toggle-format key events.
// Latency: ps2_key updates one clk_sys cycle after the rx_valid pulse that completes an event.
// Backpressure: none; events are level-held in ps2_key and signalled by the toggle bit.
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 2000,
    parameter int TIMEOUT_W = 12
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic [10:0] ps2_key,
    output logic        key_busy
);

    logic [7:0]  w_byte;
    logic        w_vld, w_perr, w_ferr;
    dec_state_t  r_state, w_state_nx;
    logic        r_ext, w_ext_nx, r_brk, w_brk_nx;
    logic [2:0]  r_skip, w_skip_nx;
    logic [10:0] r_key, w_key_nx;

    ps2_frame_rx #(
        .FILTER    (FILTER),
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_frame_rx (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_rx_byte    (w_byte),
        .o_rx_valid   (w_vld),
        .o_parity_err (w_perr),
        .o_frame_err  (w_ferr)
    );

    always_comb begin
        w_state_nx = r_state;
        w_ext_nx   = r_ext;
        w_brk_nx   = r_brk;
        w_skip_nx  = r_skip;
        w_key_nx   = r_key;

        // Any bad frame abandons a partial sequence so a corrupt one never emits a key.
        if (w_perr || w_ferr) begin
            w_state_nx = D_IDLE;
            w_ext_nx   = 1'b0;
            w_brk_nx   = 1'b0;
            w_skip_nx  = 3'd0;
        end else if (w_vld) begin
            unique case (r_state)
                D_IDLE: begin
                    if (w_byte == PS2_EXT) begin
                        w_ext_nx = 1'b1;
                    end else if (w_byte == PS2_BRK) begin
                        w_brk_nx = 1'b1;
                    end else if (w_byte == PS2_PAUSE) begin
                        w_state_nx = D_SKIP;
                        w_skip_nx  = 3'd7;
                        w_ext_nx   = 1'b0;
                        w_brk_nx   = 1'b0;
                    end else begin
                        // Extended left-shift is the Print-Screen fake shift: drop it.
                        if (!(r_ext && w_byte == PS2_LSHIFT)) begin
                            w_key_nx[KEY_TOGGLE]  = ~r_key[KEY_TOGGLE];
                            w_key_nx[KEY_PRESSED] = ~r_brk;
                            w_key_nx[KEY_EXT]     = r_ext;
                            w_key_nx[7:0]         = w_byte;
                        end
                        w_ext_nx = 1'b0;
                        w_brk_nx = 1'b0;
                    end
                end
                D_SKIP: begin
                    if (r_skip == 3'd1) begin
                        w_key_nx[KEY_TOGGLE]  = ~r_key[KEY_TOGGLE];
                        w_key_nx[KEY_PRESSED] = 1'b1;
                        w_key_nx[KEY_EXT]     = 1'b1;
                        w_key_nx[7:0]         = PS2_PAUSE_CODE;
                        w_state_nx            = D_IDLE;
                        w_skip_nx             = 3'd0;
                    end else begin
                        w_skip_nx = r_skip - 3'd1;
                    end
                end
                default: w_state_nx = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= D_IDLE;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_skip  <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ext   <= w_ext_nx;
            r_brk   <= w_brk_nx;
            r_skip  <= w_skip_nx;
            r_key   <= w_key_nx;
        end
    end

    assign rx_byte    = w_byte;
    assign rx_valid   = w_vld;
    assign parity_err = w_perr;
    assign frame_err  = w_ferr;
    assign ps2_key    = r_key;
    assign key_busy   = r_ext | r_brk | (r_state == D_SKIP);

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Bench for ps2_rx_decoder: directed scan-code sequences plus random frames against a sequence-level model.
module tb_ps2_rx_decoder;
    import ps2_pkg::*;

    localparam int TIMEOUT = 2000;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_valid, parity_err, frame_err, key_busy;
    logic [10:0] ps2_key;

    ps2_rx_decoder #(.FILTER(4), .TIMEOUT(TIMEOUT), .TIMEOUT_W(12)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .ps2_key    (ps2_key),
        .key_busy   (key_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // kind: 0 = good byte, 1 = parity error, 2 = frame error
    typedef struct {
        int         kind;
        logic [7:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pend[$];
    logic [10:0] m_key  = '0;
    logic [7:0]  m_byte = '0;
    int          ferr_cyc  = 0;
    int          last_fall = 0;

    function automatic void model_emit(input logic [9:0] v);
        m_key = {~m_key[10], v};
    endfunction

    // Sequence-level view: a key event is a run of E0/F0 prefixes closed by a code
    // byte; an E1 run is exactly eight bytes and means Pause.
    function automatic void model_byte(input logic [7:0] b);
        bit ext, brk;
        pend.push_back(b);
        if (pend[0] == PS2_PAUSE) begin
            if (pend.size() == 8) begin
                model_emit({2'b11, PS2_PAUSE_CODE});
                pend.delete();
            end
        end else if (b == PS2_PAUSE) begin
            pend.delete();
            pend.push_back(b);
        end else if (b != PS2_EXT && b != PS2_BRK) begin
            ext = 0;
            brk = 0;
            foreach (pend[i]) begin
                if (pend[i] == PS2_EXT) ext = 1;
                if (pend[i] == PS2_BRK) brk = 1;
            end
            pend.delete();
            if (!(ext && b == PS2_LSHIFT)) model_emit({~brk, ext, b});
        end
    endfunction

    always @(negedge clk_sys) begin
        int   kind;
        exp_t e;
        if (!reset_n) begin
            m_key  = '0;
            m_byte = '0;
            pend.delete();
            exp_q.delete();
            n_checks++;
            if ({rx_byte, rx_valid, parity_err, frame_err, ps2_key, key_busy} !== 23'd0) begin
                n_errors++;
                $display("FAIL reset_outputs: got byte=%h v=%b pe=%b fe=%b key=%h busy=%b, want all 0",
                         rx_byte, rx_valid, parity_err, frame_err, ps2_key, key_busy);
            end
        end else begin
            n_checks++;
            if (ps2_key !== m_key || key_busy !== (pend.size() != 0) ||
                (!rx_valid && rx_byte !== m_byte)) begin
                n_errors++;
                $display("FAIL cycle_state @%0d: got key=%h busy=%b byte=%h, want key=%h busy=%b byte=%h",
                         cyc, ps2_key, key_busy, rx_byte, m_key, pend.size() != 0, m_byte);
            end
            if (rx_valid || parity_err || frame_err) begin
                n_checks++;
                kind = rx_valid ? 0 : (parity_err ? 1 : 2);
                if (frame_err) ferr_cyc = cyc;
                if ((int'(rx_valid) + int'(parity_err) + int'(frame_err)) > 1 || exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL pulse_unexpected @%0d: got v=%b pe=%b fe=%b, want %0d pending pulses",
                             cyc, rx_valid, parity_err, frame_err, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || (kind == 0 && rx_byte !== e.b)) begin
                        n_errors++;
                        $display("FAIL pulse_kind @%0d: got kind=%0d byte=%h, want kind=%0d byte=%h",
                                 cyc, kind, rx_byte, e.kind, e.b);
                    end
                    if (e.kind == 0) begin
                        m_byte = e.b;
                        model_byte(e.b);
                    end else begin
                        pend.delete();
                    end
                end
            end
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int hp,
                             input bit glitch, input bit last_rise);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                wcyc(hp / 2);
                ps2_clk = 1'b0;
                wcyc(2);
                ps2_clk = 1'b1;
                wcyc(hp - hp / 2 - 2);
            end else begin
                wcyc(hp);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wcyc(hp);
            if (i < nbits - 1 || last_rise) ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int hp, input bit glitch);
        logic  par;
        exp_t  e;
        par    = (~^b) ^ bad_par;
        e.b    = b;
        e.kind = bad_stop ? 2 : (bad_par ? 1 : 0);
        exp_q.push_back(e);
        send_bits({~bad_stop, par, b, 1'b0}, 11, hp, glitch, 1'b1);
        ps2_data = 1'b1;
        wcyc(hp);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL frame_pulse byte=%h: got %0d pulses outstanding, want 0", b, exp_q.size());
        end
    endtask

    task automatic check_key(input string name, input logic [10:0] want);
        n_checks++;
        if (ps2_key !== want) begin
            n_errors++;
            $display("FAIL %s: got ps2_key=%h, want %h", name, ps2_key, want);
        end
        n_checks++;
        if (m_key !== want) begin
            n_errors++;
            $display("FAIL %s_model: got model key=%h, want %h", name, m_key, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] seq_pause[8];
        logic [7:0] b;
        exp_t       e;
        int         r, lat;

        seq_pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        wcyc(5);
        check_key("reset_key", 11'h000);
        check_bit("reset_busy", key_busy, 1'b0);
        reset_n = 1'b1;
        wcyc(20);

        send_frame(8'h1C, 0, 0, 101, 0);
        check_key("make_1c", 11'h61C);
        check_bit("byte_1c", rx_byte == 8'h1C, 1'b1);

        send_frame(PS2_EXT, 0, 0, 101, 0);
        check_bit("busy_after_e0", key_busy, 1'b1);
        send_frame(PS2_BRK, 0, 0, 101, 0);
        send_frame(8'h75, 0, 0, 101, 0);
        check_key("ext_release_75", 11'h175);
        check_bit("busy_after_75", key_busy, 1'b0);

        send_frame(8'h1C, 1, 0, 101, 0);
        check_key("parity_err_hold", 11'h175);

        foreach (seq_pause[i]) send_frame(seq_pause[i], 0, 0, 101, 0);
        check_key("pause", 11'h777);

        e.kind = 2;
        e.b    = 8'h00;
        exp_q.push_back(e);
        send_bits({6'b000000, 4'b0110, 1'b0}, 5, 101, 0, 1'b1);
        ps2_data = 1'b1;
        wcyc(2500);
        lat = ferr_cyc - last_fall;
        n_checks++;
        if (exp_q.size() != 0 || lat < TIMEOUT + 6 || lat > TIMEOUT + 8) begin
            n_errors++;
            $display("FAIL timeout: got latency=%0d outstanding=%0d, want latency %0d..%0d outstanding=0",
                     lat, exp_q.size(), TIMEOUT + 6, TIMEOUT + 8);
        end
        send_frame(8'h29, 0, 0, 101, 0);
        check_key("after_timeout_29", 11'h229);

        send_frame(8'h1C, 0, 0, 101, 1);
        check_key("glitch_1c", 11'h61C);

        send_bits({7'b0000000, 3'b101, 1'b0}, 4, 101, 0, 1'b0);
        ps2_data = 1'b0;
        reset_n  = 1'b0;
        wcyc(5);
        check_key("reset_mid_key", 11'h000);
        check_bit("reset_mid_busy", key_busy, 1'b0);
        reset_n = 1'b1;
        wcyc(40);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wcyc(40);
        send_frame(8'h5A, 0, 0, 101, 0);
        check_key("after_reset_5a", 11'h65A);

        send_frame(PS2_EXT, 0, 0, 30, 0);
        send_frame(PS2_LSHIFT, 0, 0, 30, 0);
        send_frame(PS2_EXT, 0, 0, 30, 0);
        send_frame(PS2_PRTSC, 0, 0, 30, 0);
        check_key("prtsc_make", 11'h37C);

        send_frame(PS2_EXT, 0, 0, 30, 0);
        send_frame(PS2_BRK, 0, 0, 30, 0);
        send_frame(PS2_PRTSC, 0, 0, 30, 0);
        check_key("prtsc_break", 11'h57C);
        send_frame(PS2_EXT, 0, 0, 30, 0);
        send_frame(PS2_BRK, 0, 0, 30, 0);
        send_frame(PS2_LSHIFT, 0, 0, 30, 0);
        check_key("prtsc_break_tail", 11'h57C);
        check_bit("prtsc_busy", key_busy, 1'b0);

        send_frame(PS2_EXT, 0, 0, 30, 0);
        send_frame(8'h11, 1, 0, 30, 0);
        send_frame(8'h75, 0, 0, 30, 0);
        check_key("err_clears_prefix", 11'h275);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      b = PS2_EXT;
            else if (r < 32) b = PS2_BRK;
            else if (r < 36) b = PS2_PAUSE;
            else if (r < 44) b = PS2_LSHIFT;
            else if (r < 50) b = PS2_PRTSC;
            else             b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            send_frame(b, r < 8, r >= 8 && r < 13, $urandom_range(12, 24), 0);
        end

        wcyc(50);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
